// File: rtl/gb_pkg.sv
// Shared Game Boy bus definitions: DMA state encoding, fixed register/OAM
// addresses and the source-page mapping used by the OAM DMA engine.
package gb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_e;

  localparam logic [15:0] REG_DMA   = 16'hFF46;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam int          OAM_SIZE  = 160;
  localparam logic [15:0] ECHO_FOLD = 16'h2000;

  // Pages E0..FF alias work RAM, so they are folded down into C000..DFFF.
  function automatic logic [15:0] dma_src_base(input logic [7:0] page);
    logic [15:0] base;
    base = {page, 8'h00};
    if (page >= 8'hE0) begin
      base = base - ECHO_FOLD;
    end
    return base;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// FF46 OAM DMA engine: register responder plus a registered bus master that
// copies LENGTH bytes from a source page into OAM. Option: OAM_DMA_RESTART_EN.
module oam_dma
  import gb_pkg::*;
#(
  parameter logic [15:0] REG_ADDR    = REG_DMA,
  parameter logic [15:0] DST_BASE    = OAM_BASE,
  parameter int          LENGTH      = OAM_SIZE,
  parameter int          START_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_w,
  input  logic        cpu_write_enable,
  output logic [7:0]  cpu_data_r,
  output logic        cpu_data_active,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_data_w,
  output logic        dma_write_enable,
  input  logic [7:0]  dma_data_r,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_DELAY = 2'(DELAY);
  localparam logic [1:0] S_READ  = 2'(READ);
  localparam logic [1:0] S_WRITE = 2'(WRITE);

  localparam logic [8:0] LAST_IDX   = 9'(LENGTH - 1);
  localparam logic [1:0] DELAY_LOAD = 2'(START_DELAY);

  logic [1:0]  state_reg;
  logic [7:0]  src_reg;
  logic [15:0] src_base_reg;
  logic [8:0]  idx_reg;
  logic [1:0]  delay_reg;
  logic [15:0] dma_addr_reg;
  logic [7:0]  byte_buf_reg;
  logic        dma_we_reg;
  logic        busy_reg;

  logic        trigger;
  logic        last_write;
  logic        start;
  logic [15:0] new_base;
  logic [8:0]  idx_next;

  assign trigger    = cpu_write_enable && (cpu_addr == REG_ADDR);
  assign new_base   = dma_src_base(cpu_data_w);
  assign last_write = (state_reg == S_WRITE) && (idx_reg == LAST_IDX);
  assign idx_next   = idx_reg + 9'd1;

`ifdef OAM_DMA_RESTART_EN
  assign start = trigger;
`else
  // A trigger landing on the final WRITE chains straight into the next copy.
  assign start = trigger && ((state_reg == S_IDLE) || last_write);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      src_reg      <= 8'hFF;
      src_base_reg <= 16'h0000;
      idx_reg      <= 9'd0;
      delay_reg    <= 2'd0;
      dma_addr_reg <= 16'h0000;
      byte_buf_reg <= 8'h00;
      dma_we_reg   <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      if (trigger) begin
        src_reg <= cpu_data_w;
      end
      if (start) begin
        src_base_reg <= new_base;
        idx_reg      <= 9'd0;
        delay_reg    <= DELAY_LOAD;
        dma_we_reg   <= 1'b0;
        busy_reg     <= 1'b1;
        if (START_DELAY == 0) begin
          state_reg    <= S_READ;
          dma_addr_reg <= new_base;
        end else begin
          state_reg <= S_DELAY;
        end
      end else begin
        case (state_reg)
          S_DELAY: begin
            if (delay_reg <= 2'd1) begin
              state_reg    <= S_READ;
              dma_addr_reg <= src_base_reg + {8'h00, idx_reg[7:0]};
            end else begin
              delay_reg <= delay_reg - 2'd1;
            end
          end
          S_READ: begin
            // Responder data is valid at the edge that ends the read cycle.
            state_reg    <= S_WRITE;
            dma_addr_reg <= DST_BASE + {8'h00, idx_reg[7:0]};
            byte_buf_reg <= dma_data_r;
            dma_we_reg   <= 1'b1;
          end
          S_WRITE: begin
            dma_we_reg <= 1'b0;
            idx_reg    <= idx_next;
            if (last_write) begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg    <= S_READ;
              dma_addr_reg <= src_base_reg + {8'h00, idx_next[7:0]};
            end
          end
          default: begin
            dma_we_reg <= 1'b0;
            busy_reg   <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    cpu_data_active = !cpu_write_enable && (cpu_addr == REG_ADDR);
    cpu_data_r      = src_reg;
  end

  assign dma_addr         = dma_addr_reg;
  assign dma_data_w       = byte_buf_reg;
  assign dma_write_enable = dma_we_reg;
  assign busy             = busy_reg;

endmodule
